// File: rtl/l2_req_queue_pkg.sv
// l2q_pkg: shared constants and types for the L2 request queue
package l2q_pkg;
    localparam int L2Q_ADDR_W = 26;
    localparam logic [3:0] CMD_RESET = 4'd8;
    typedef logic [L2Q_ADDR_W-1:0] line_addr_t;
endpackage

// File: rtl/l2_req_queue_if.sv
// l2_req_queue_if: enqueue/dequeue handshake between data cache, queue and next-level cache
interface l2_req_queue_if
    import l2q_pkg::*;
#(
    parameter int ADDR_W = L2Q_ADDR_W
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    modport master (output in_valid, in_addr, out_ready, input in_ready, out_valid, out_addr);
    modport slave  (input in_valid, in_addr, out_ready, output in_ready, out_valid, out_addr);
endinterface

// File: rtl/l2_req_queue.sv
// l2_req_queue: first-word fall-through line-address queue toward the next-level cache.
// Define L2Q_COALESCE_EN to absorb pushes that repeat the most recently queued address.
module l2_req_queue
    import l2q_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = L2Q_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [3:0]               n,
    l2_req_queue_if.slave            bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic [31:0]              issued,
    output logic [31:0]              coalesced
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
    localparam logic [PW:0] ONE  = (PW+1)'(1);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic              cmd_rst, push, pop, match, store;

    assign cmd_rst       = n == CMD_RESET;
    assign bus.out_valid = !cmd_rst && count != '0;
    assign bus.out_addr  = mem[rd_ptr];
    assign pop           = bus.out_valid && bus.out_ready;

`ifdef L2Q_COALESCE_EN
    logic [PW-1:0] last_ptr;
    assign last_ptr = wr_ptr - 1'b1;
    // The newest entry cannot absorb a push in the cycle it leaves the queue.
    assign match = count != '0 && bus.in_addr == mem[last_ptr] && !(pop && count == ONE);
    always_ff @(posedge clk or posedge rst)
        if (rst) coalesced <= '0;
        else coalesced <= cmd_rst ? '0 : coalesced + 32'(push && match);
`else
    assign match     = 1'b0;
    assign coalesced = '0;
`endif

    assign bus.in_ready = !rst && !cmd_rst && (count < FULL || match);
    assign push         = bus.in_valid && bus.in_ready;
    assign store        = push && !match;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            issued <= '0;
        end else begin
            rd_ptr <= cmd_rst ? '0 : rd_ptr + PW'(pop);
            wr_ptr <= cmd_rst ? '0 : wr_ptr + PW'(store);
            count  <= cmd_rst ? '0 : count + (PW+1)'(store) - (PW+1)'(pop);
            issued <= cmd_rst ? '0 : issued + 32'(pop);
        end

    always_ff @(posedge clk)
        if (store) mem[wr_ptr] <= bus.in_addr;
endmodule

// File: tb/tb_l2_req_queue.sv
// tb_l2_req_queue: table vectors, directed corner sequences and randomized traffic against a queue model
module tb_l2_req_queue;
    import l2q_pkg::*;
    localparam int DEPTH = 4;
`ifdef L2Q_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  n = '0;
    logic [2:0]  count;
    logic [31:0] issued, coalesced;

    l2_req_queue_if #(.ADDR_W(L2Q_ADDR_W)) bus ();

    l2_req_queue #(.DEPTH(DEPTH), .ADDR_W(L2Q_ADDR_W)) dut (
        .clk(clk), .rst(rst), .n(n), .bus(bus.slave),
        .count(count), .issued(issued), .coalesced(coalesced)
    );

    always #5 clk = ~clk;

    int          n_chk = 0, n_fail = 0;
    line_addr_t  mq[$];
    logic [31:0] m_issued = '0, m_coal = '0;

    typedef struct {
        logic        iv;
        line_addr_t  a;
        logic        ordy;
        logic [3:0]  nn;
        logic        ir;
        logic        ov;
        line_addr_t  oa;
        logic [2:0]  cnt;
        logic [31:0] iss;
    } vec_t;
    vec_t tv[10];

    function automatic bit m_ov();
        return n != CMD_RESET && mq.size() > 0;
    endfunction
    function automatic bit m_pop();
        return m_ov() && bus.out_ready;
    endfunction
    function automatic bit m_match();
        return COAL && mq.size() > 0 && bus.in_addr == mq[mq.size()-1] && !(m_pop() && mq.size() == 1);
    endfunction
    function automatic bit m_ir();
        return !rst && n != CMD_RESET && (mq.size() < DEPTH || m_match());
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iv, input line_addr_t a, input logic ordy, input logic [3:0] nn);
        bus.in_valid  = iv;
        bus.in_addr   = a;
        bus.out_ready = ordy;
        n             = nn;
        #1;
    endtask

    task automatic check_model();
        chk("in_ready", 32'(bus.in_ready), 32'(m_ir()));
        chk("out_valid", 32'(bus.out_valid), 32'(m_ov()));
        if (m_ov()) chk("out_addr", 32'(bus.out_addr), 32'(mq[0]));
        chk("count", 32'(count), 32'(mq.size()));
        chk("issued", issued, m_issued);
        chk("coalesced", coalesced, m_coal);
    endtask

    task automatic tick();
        bit push, pop, match;
        push  = bus.in_valid && m_ir();
        pop   = m_pop();
        match = m_match();
        @(posedge clk);
        if (n == CMD_RESET) begin
            mq.delete();
            m_issued = '0;
            m_coal   = '0;
        end else begin
            if (pop) begin
                void'(mq.pop_front());
                m_issued++;
            end
            if (push) begin
                if (match) m_coal++;
                else mq.push_back(bus.in_addr);
            end
        end
        @(negedge clk);
    endtask

    task automatic step(input logic iv, input line_addr_t a, input logic ordy, input logic [3:0] nn);
        drive(iv, a, ordy, nn);
        check_model();
        tick();
    endtask

    initial begin
        tv[0] = '{1'b1, 26'hABC, 1'b0, 4'd0, 1'b1, 1'b0, 26'h0,   3'd0, 32'd0};
        tv[1] = '{1'b0, 26'h0,   1'b0, 4'd0, 1'b1, 1'b1, 26'hABC, 3'd1, 32'd0};
        tv[2] = '{1'b1, 26'h111, 1'b0, 4'd0, 1'b1, 1'b1, 26'hABC, 3'd1, 32'd0};
        tv[3] = '{1'b1, 26'h222, 1'b0, 4'd0, 1'b1, 1'b1, 26'hABC, 3'd2, 32'd0};
        tv[4] = '{1'b1, 26'h333, 1'b0, 4'd0, 1'b1, 1'b1, 26'hABC, 3'd3, 32'd0};
        tv[5] = '{1'b1, 26'h444, 1'b0, 4'd0, 1'b0, 1'b1, 26'hABC, 3'd4, 32'd0};
        tv[6] = '{1'b1, 26'h555, 1'b1, 4'd0, 1'b0, 1'b1, 26'hABC, 3'd4, 32'd0};
        tv[7] = '{1'b0, 26'h0,   1'b0, 4'd0, 1'b1, 1'b1, 26'h111, 3'd3, 32'd1};
        tv[8] = '{1'b1, 26'h666, 1'b1, 4'd8, 1'b0, 1'b0, 26'h0,   3'd3, 32'd1};
        tv[9] = '{1'b0, 26'h0,   1'b0, 4'd0, 1'b1, 1'b0, 26'h0,   3'd0, 32'd0};

        bus.in_valid = 1'b0; bus.in_addr = '0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_issued", issued, 32'd0);
        chk("rst_coalesced", coalesced, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(tv[i].iv, tv[i].a, tv[i].ordy, tv[i].nn);
            chk($sformatf("tv%0d_in_ready", i), 32'(bus.in_ready), 32'(tv[i].ir));
            chk($sformatf("tv%0d_out_valid", i), 32'(bus.out_valid), 32'(tv[i].ov));
            if (tv[i].ov) chk($sformatf("tv%0d_out_addr", i), 32'(bus.out_addr), 32'(tv[i].oa));
            chk($sformatf("tv%0d_count", i), 32'(count), 32'(tv[i].cnt));
            chk($sformatf("tv%0d_issued", i), issued, tv[i].iss);
            check_model();
            tick();
        end

        step(1'b1, 26'h1000, 1'b0, 4'd0);
        step(1'b1, 26'h1000, 1'b0, 4'd0);
        drive(1'b0, '0, 1'b0, 4'd0);
        chk("coal_count", 32'(count), COAL ? 32'd1 : 32'd2);
        chk("coal_coalesced", coalesced, COAL ? 32'd1 : 32'd0);
        step(1'b1, 26'h2000, 1'b0, 4'd0);
        step(1'b1, 26'h1000, 1'b0, 4'd0);
        drive(1'b0, '0, 1'b0, 4'd0);
        chk("dup_count", 32'(count), COAL ? 32'd3 : 32'd4);
        repeat (5) step(1'b0, '0, 1'b1, 4'd0);

        step(1'b0, '0, 1'b0, CMD_RESET);
        for (int i = 0; i < 16; i++) step(i < 6, line_addr_t'(26'h200 + i), i[0], 4'd0);
        chk("wrap_issued", issued, 32'd6);

        step(1'b1, 26'h300, 1'b0, 4'd0);
        step(1'b1, 26'h301, 1'b0, 4'd0);
        drive(1'b1, 26'h302, 1'b1, 4'd0);
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("arst_issued", issued, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        m_issued = '0;
        m_coal   = '0;
        step(1'b0, '0, 1'b0, 4'd0);

        for (int i = 0; i < 600; i++)
            step(1'(($urandom_range(0, 3)) != 0), line_addr_t'(16 * $urandom_range(1, 3)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 31) == 0) ? CMD_RESET : 4'($urandom_range(0, 7)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
